// File: rtl/hdec_arbiter.sv
// Round-robin arbiter feeding one shared half-decoder into a single-entry output register.
// The granted requester's amount becomes a thermometer mask with bit j set iff j < amt.
module hdec_arbiter #(
  parameter int NREQ = 4,
  parameter int N    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*N-1:0]            req_amt,
  output logic [NREQ-1:0]              req_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [(2**N)-1:0]            out_mask,
  output logic [$clog2(NREQ)-1:0]      out_id
);

  localparam int IDW = $clog2(NREQ);
  localparam int MW  = 2 ** N;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_idx;
  logic           any_req;
  logic           accept;
  logic           grant;
  logic [N-1:0]   amt_sel;
  logic [MW-1:0]  mask_d;
  logic [IDW-1:0] ptr_next;

  assign accept = !out_valid || out_ready;

  // Descending scan so the lowest offset from ptr is the one that sticks.
  always_comb begin
    any_req   = 1'b0;
    grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        any_req   = 1'b1;
        grant_idx = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // rst_n gating keeps req_ready low while the block is held in reset.
  assign grant = accept && any_req && rst_n;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  assign amt_sel  = req_amt[grant_idx*N +: N];
  assign ptr_next = IDW'((int'(grant_idx) + 1) % NREQ);

  always_comb begin
    mask_d = '0;
    for (int j = 0; j < MW; j++) begin
      mask_d[j] = (j < int'(amt_sel));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mask  <= '0;
      out_id    <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= grant;
      if (grant) begin
        out_mask <= mask_d;
        out_id   <= grant_idx;
        ptr      <= ptr_next;
      end
    end
  end

endmodule

// File: doc/hdec_arbiter.md
HDEC_ARBITER -- requirements
Module: hdec_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, the number of requesters; legal range 2..8.
REQ-002 SHALL have parameter N, default 4, the shift-amount width; legal values 1, 2, 4 and 8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, NREQ bits: bit i set means requester i presents an amount.
REQ-006 SHALL have port req_amt, input, NREQ*N bits: requester i's amount is in slice [i*N +: N].
REQ-007 SHALL have port req_ready, output, NREQ bits: one-hot or zero; bit i set means requester i is accepted this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: out_mask and out_id hold a result.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port out_mask, output, 2**N bits: half-decoded mask of the granted amount.
REQ-011 SHALL have port out_id, output, clog2(NREQ) bits: index of the requester that produced out_mask.

Function
REQ-012 SHALL compute the mask with one shared half-decoder: out_mask[j]=1 iff j < amt (unsigned). Examples: amt=0 gives all zeros; amt=2**N-1 gives all ones except the MSB.
REQ-013 SHALL hold a one-entry output register (out_valid, out_mask, out_id) and a round-robin pointer ptr of width clog2(NREQ).
REQ-014 SHALL define accept = !out_valid | out_ready.
REQ-015 SHALL, when accept=1 and any req_valid bit is set, grant the first set bit at or after ptr, searching upward with wrap-around to 0. The grant is combinational in the same cycle.
REQ-016 SHALL drive req_ready[g]=1 only for the granted index g, and only when accept=1; otherwise req_ready SHALL be all zeros.
REQ-017 SHALL make req_ready independent of req_amt. req_ready SHALL NOT depend combinationally on out_mask.
REQ-018 SHALL, on a grant, load out_mask=decode(req_amt[g]), out_id=g and out_valid=1 at the next edge, giving 1-cycle latency from handshake to result.
REQ-019 SHALL, on a grant, update ptr to (g+1) mod NREQ. When no grant occurs, ptr SHALL be unchanged.
REQ-020 SHALL, when accept=1 and no req_valid bit is set, clear out_valid at the next edge if out_ready=1 (drain). out_mask and out_id SHALL then hold their last values.
REQ-021 SHALL, when out_valid=1 and out_ready=0 (stall), hold out_mask, out_id, out_valid and ptr unchanged, and keep req_ready at all zeros.
REQ-022 SHALL, when out_valid=1, out_ready=1 and a request is present, complete the pop and the new grant in the same cycle. Back-to-back throughput SHALL be one result per cycle.
REQ-023 SHALL guarantee no starvation: a requester whose valid is held high is granted within NREQ grants.
REQ-024 SHALL treat req_valid deasserting without a handshake as legal; no state changes result.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force out_valid=0, out_mask=0, out_id=0 and ptr=0. req_ready SHALL then read all zeros.
REQ-026 SHALL discard any in-flight result when reset asserts mid-operation. The first grant after reset release SHALL favour requester 0.

Verification
REQ-027 Single request: NREQ=4, N=4, req_valid=0100, amt2=5, out_ready=1 -> req_ready=0100 in the same cycle; the next cycle has out_valid=1, out_mask=0x001F, out_id=2.
REQ-028 Round-robin: all four requesters valid continuously with out_ready=1 -> out_id sequence 0,1,2,3,0 on consecutive cycles.
REQ-029 Stall: a result is pending and out_ready=0 for 3 cycles with requests present -> req_ready=0 and out_mask stable for all 3 cycles; ptr is unchanged.
REQ-030 Boundaries: amt=0 -> out_mask=0x0000; amt=15 -> out_mask=0x7FFF.
REQ-031 Wrap: ptr=3 with req_valid=0011 -> grant index 0, then ptr=1.
REQ-032 Reset mid-operation: assert rst_n=0 while out_valid=1 -> out_valid=0 immediately, with no clock edge needed. After release, with all requesters valid, the first out_id=0.
